match_filter_ctrl: RTL and testbench

MATCH_FILTER_CTRL -- requirements
Module: match_filter_ctrl

---
 rtl/match_filter_ctrl_pkg.sv | 38 +++
 rtl/match_filter_ctrl_sat_counter.sv | 27 ++
 rtl/match_filter_ctrl.sv | 178 +++++++++++++++++
 tb/tb_match_filter_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/match_filter_ctrl_pkg.sv
// Shared definitions for the match filter controller.
// Holds the controller state encoding, default sizing, and the bit positions
// of the fields inside the configuration words streamed to the filter.
package match_filter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2,
    ST_ARMED = 2'd3
  } mfc_state_e;

  // Default sizing
  localparam int NUM_WORDS_DEF   = 8;
  localparam int BUSY_CYCLES_DEF = 8;

  // Port widths
  localparam int CFG_W       = 32;
  localparam int CSTATE_W    = 3;
  localparam int HOLD_W      = 16;
  localparam int MATCH_CNT_W = 16;
  localparam int DROP_CNT_W  = 8;

  // Word 0 layout: {threshold, unused, offset, residual}
  localparam int THRESH_MSB   = 31;
  localparam int THRESH_LSB   = 16;
  localparam int OFFSET_MSB   = 7;
  localparam int OFFSET_LSB   = 3;
  localparam int RESIDUAL_MSB = 2;
  localparam int RESIDUAL_LSB = 0;

  // Words 1..NUM_WORDS-1 layout: {coef_real, coef_img}
  localparam int COEF_REAL_MSB = 31;
  localparam int COEF_REAL_LSB = 16;
  localparam int COEF_IMG_MSB  = 15;
  localparam int COEF_IMG_LSB  = 0;

endpackage

// File: rtl/match_filter_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, reset  clock and asynchronous active-low reset
//   clr         zero the count on the next edge; wins over inc
//   inc         add one unless already at all-ones
//   count       current count value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/match_filter_ctrl.sv
// Match filter controller.
// Gates receive strobes into the filter, reloads the filter configuration
// from the host once the filter has finished its current computation, and
// turns filter match results into rate-limited match pulses plus statistics.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   cfg_valid/cfg_data/cfg_last/cfg_ready
//                         host configuration stream
//   rxstrobe_in/rxstrobe_out
//                         sample strobe in, gated strobe to the filter
//   cwrite/cstate/cdata   filter configuration write port
//   f_valid/f_match       filter result
//   holdoff               minimum spacing between match pulses
//   clr_stats             clear match_cnt, drop_cnt, cfg_err
//   match_pulse/match_cnt/drop_cnt/cfg_err/armed
//                         status outputs
//   fsm_state             current controller state (debug)
//
// Config handshake: a word transfers on every rising edge where cfg_valid
// and cfg_ready are both high; cfg_ready only depends on state, and the host
// holds cfg_data/cfg_last stable while cfg_valid is high and cfg_ready low.
module match_filter_ctrl
  import match_filter_ctrl_pkg::*;
#(
  parameter int NUM_WORDS   = NUM_WORDS_DEF,   // 1..8
  parameter int BUSY_CYCLES = BUSY_CYCLES_DEF  // >= 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  input  logic [CFG_W-1:0]       cfg_data,
  input  logic                   cfg_last,
  output logic                   cfg_ready,
  input  logic                   rxstrobe_in,
  output logic                   rxstrobe_out,
  output logic                   cwrite,
  output logic [CSTATE_W-1:0]    cstate,
  output logic [CFG_W-1:0]       cdata,
  input  logic                   f_valid,
  input  logic                   f_match,
  input  logic [HOLD_W-1:0]      holdoff,
  input  logic                   clr_stats,
  output logic                   match_pulse,
  output logic [MATCH_CNT_W-1:0] match_cnt,
  output logic [DROP_CNT_W-1:0]  drop_cnt,
  output logic                   cfg_err,
  output logic                   armed,
  output mfc_state_e             fsm_state
);

  localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);

  mfc_state_e          state_q, state_d;
  logic [BUSY_W-1:0]   busy_q;
  logic [CSTATE_W-1:0] widx_q;
  logic [HOLD_W-1:0]   hold_q;

  logic pass_state;
  logic fwd;
  logic blocked;
  logic accept;
  logic last_idx;
  logic busy_done;
  logic hit;

  assign pass_state = (state_q == ST_IDLE) || (state_q == ST_ARMED);
  // Strobe is a pure combinational gate; reset term keeps it low while
  // reset is asserted.
  assign fwd       = reset && rxstrobe_in && pass_state;
  assign blocked   = rxstrobe_in && !pass_state;
  assign accept    = cfg_valid && (state_q == ST_LOAD);
  assign last_idx  = (widx_q == CSTATE_W'(NUM_WORDS - 1));
  // Leave DRAIN on the edge where the busy counter reaches 0, so LOAD is
  // the first cycle in which the counter reads 0.
  assign busy_done = (busy_q <= BUSY_W'(1));
  assign hit       = f_valid && f_match;

  assign rxstrobe_out = fwd;
  assign cfg_ready    = (state_q == ST_LOAD);
  assign armed        = (state_q == ST_ARMED);
  assign fsm_state    = state_q;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cfg_valid) state_d = ST_DRAIN;
      ST_DRAIN: if (busy_done) state_d = ST_LOAD;
      ST_LOAD: begin
        if (accept) begin
          if (last_idx)      state_d = ST_ARMED;
          else if (cfg_last) state_d = ST_IDLE;
        end
      end
      ST_ARMED: if (cfg_valid) state_d = ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Filter busy window: restarts on every strobe the filter actually sees.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else if (fwd) begin
      busy_q <= BUSY_W'(BUSY_CYCLES);
    end else if (busy_q != '0) begin
      busy_q <= busy_q - BUSY_W'(1);
    end
  end

  // Config write port and word index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      widx_q <= '0;
      cwrite <= 1'b0;
      cstate <= '0;
      cdata  <= '0;
    end else begin
      cwrite <= accept;
      if (accept) begin
        cdata  <= cfg_data;
        cstate <= widx_q;
      end
      if (state_q != ST_LOAD) widx_q <= '0;
      else if (accept)        widx_q <= widx_q + CSTATE_W'(1);
    end
  end

  // Load error: cfg_last must coincide exactly with the final word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_err <= 1'b0;
    end else if (clr_stats) begin
      cfg_err <= 1'b0;
    end else if (accept && (last_idx ? !cfg_last : cfg_last)) begin
      cfg_err <= 1'b1;
    end
  end

  // Match pulse with holdoff; the holdoff counter runs down in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_pulse <= 1'b0;
      hold_q      <= '0;
    end else begin
      match_pulse <= 1'b0;
      if ((state_q == ST_ARMED) && hit && (hold_q == '0)) begin
        match_pulse <= 1'b1;
        hold_q      <= holdoff;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - HOLD_W'(1);
      end
    end
  end

  sat_counter #(.W(MATCH_CNT_W)) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_stats),
    .inc   (hit),
    .count (match_cnt)
  );

  sat_counter #(.W(DROP_CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_stats),
    .inc   (blocked),
    .count (drop_cnt)
  );

endmodule

// File: tb/tb_match_filter_ctrl.sv
module tb_match_filter_ctrl;
  import match_filter_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        cfg_valid = 1'b0;
  logic [31:0] cfg_data = '0;
  logic        cfg_last = 1'b0;
  logic        cfg_ready;
  logic        rxstrobe_in = 1'b0;
  logic        rxstrobe_out;
  logic        cwrite;
  logic [2:0]  cstate;
  logic [31:0] cdata;
  logic        f_valid = 1'b0;
  logic        f_match = 1'b0;
  logic [15:0] holdoff = '0;
  logic        clr_stats = 1'b0;
  logic        match_pulse;
  logic [15:0] match_cnt;
  logic [7:0]  drop_cnt;
  logic        cfg_err;
  logic        armed;
  mfc_state_e  fsm_state;

  match_filter_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .cfg_last     (cfg_last),
    .cfg_ready    (cfg_ready),
    .rxstrobe_in  (rxstrobe_in),
    .rxstrobe_out (rxstrobe_out),
    .cwrite       (cwrite),
    .cstate       (cstate),
    .cdata        (cdata),
    .f_valid      (f_valid),
    .f_match      (f_match),
    .holdoff      (holdoff),
    .clr_stats    (clr_stats),
    .match_pulse  (match_pulse),
    .match_cnt    (match_cnt),
    .drop_cnt     (drop_cnt),
    .cfg_err      (cfg_err),
    .armed        (armed),
    .fsm_state    (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] words [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input mfc_state_e s, input string tag);
    int n = 0;
    while (fsm_state != s && n < 50) begin
      tick();
      n++;
    end
    chk(tag, 32'(fsm_state), 32'(s));
  endtask

  task automatic set_hit(input logic v);
    f_valid = v;
    f_match = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    words[0] = 32'h0010_0012;
    for (int i = 1; i < 8; i++) words[i] = 32'h4000_0000 | i;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    chk("rst_cwrite", 32'(cwrite), 32'd0);
    chk("rst_cdata", cdata, 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_pulse", 32'(match_pulse), 32'd0);
    chk("rst_match_cnt", 32'(match_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    reset = 1'b1;
    tick();

    // Cycle t: strobe forwarded in IDLE
    rxstrobe_in = 1'b1;
    #1 chk("fwd_idle", 32'(rxstrobe_out), 32'd1);
    tick();
    // t+1: config request
    rxstrobe_in = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = words[0];
    cfg_last  = 1'b0;
    tick();
    // t+2..t+8: DRAIN, strobes blocked and counted
    for (int k = 2; k <= 8; k++) begin
      chk($sformatf("drain_t%0d", k), 32'(fsm_state), 32'(ST_DRAIN));
      chk($sformatf("drain_ready_t%0d", k), 32'(cfg_ready), 32'd0);
      if (k == 3 || k == 5) begin
        rxstrobe_in = 1'b1;
        #1 chk($sformatf("blocked_t%0d", k), 32'(rxstrobe_out), 32'd0);
      end
      tick();
      rxstrobe_in = 1'b0;
    end
    // t+9: LOAD
    chk("load_t9", 32'(fsm_state), 32'(ST_LOAD));
    chk("ready_t9", 32'(cfg_ready), 32'd1);
    chk("drop_cnt_2", 32'(drop_cnt), 32'd2);

    // Full 8-word load
    for (int i = 0; i < 8; i++) begin
      cfg_data = words[i];
      cfg_last = (i == 7);
      tick();
      chk($sformatf("cwrite_%0d", i), 32'(cwrite), 32'd1);
      chk($sformatf("cstate_%0d", i), 32'(cstate), i);
      chk($sformatf("cdata_%0d", i), cdata, words[i]);
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    chk("armed_after_load", 32'(armed), 32'd1);
    chk("cfg_err_after_load", 32'(cfg_err), 32'd0);
    tick();
    chk("cwrite_done", 32'(cwrite), 32'd0);
    chk("cdata_hold", cdata, words[7]);
    chk("cstate_hold", 32'(cstate), 32'd7);

    // Holdoff = 10, matches at 0, 5, 12 -> pulses at 1 and 13
    holdoff = 16'd10;
    for (int c = 0; c <= 14; c++) begin
      chk($sformatf("hold10_pulse_c%0d", c), 32'(match_pulse),
          (c == 1 || c == 13) ? 32'd1 : 32'd0);
      set_hit(c == 0 || c == 5 || c == 12);
      tick();
    end
    set_hit(1'b0);
    chk("hold10_match_cnt", 32'(match_cnt), 32'd3);
    repeat (12) tick();

    // Holdoff = 0: pulse for every match
    holdoff = 16'd0;
    for (int c = 0; c <= 4; c++) begin
      chk($sformatf("hold0_pulse_c%0d", c), 32'(match_pulse),
          (c >= 1 && c <= 3) ? 32'd1 : 32'd0);
      set_hit(c <= 2);
      tick();
    end
    set_hit(1'b0);
    chk("hold0_match_cnt", 32'(match_cnt), 32'd6);

    // Reload request while holdoff is active
    holdoff = 16'd10;
    set_hit(1'b1);
    tick();
    set_hit(1'b0);
    chk("reload_pulse", 32'(match_pulse), 32'd1);
    cfg_valid = 1'b1;
    cfg_data  = words[0];
    tick();
    chk("reload_drain", 32'(fsm_state), 32'(ST_DRAIN));
    wait_state(ST_LOAD, "reload_load");

    // Partial load: cfg_last on 3rd word
    for (int i = 0; i < 3; i++) begin
      cfg_data = words[i];
      cfg_last = (i == 2);
      tick();
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    chk("partial_cfg_err", 32'(cfg_err), 32'd1);
    chk("partial_state", 32'(fsm_state), 32'(ST_IDLE));
    chk("partial_armed", 32'(armed), 32'd0);
    chk("partial_cwrite", 32'(cwrite), 32'd1);
    chk("partial_cstate", 32'(cstate), 32'd2);
    chk("partial_match_cnt", 32'(match_cnt), 32'd7);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_cfg_err", 32'(cfg_err), 32'd0);
    chk("clr_match_cnt", 32'(match_cnt), 32'd0);
    chk("clr_drop_cnt", 32'(drop_cnt), 32'd0);

    // match_cnt saturation
    set_hit(1'b1);
    repeat (65535) tick();
    chk("match_cnt_max", 32'(match_cnt), 32'd65535);
    tick();
    chk("match_cnt_sat", 32'(match_cnt), 32'd65535);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    set_hit(1'b0);
    chk("clr_wins_match", 32'(match_cnt), 32'd0);

    // drop_cnt saturation while parked in LOAD
    cfg_valid = 1'b1;
    cfg_data  = words[0];
    tick();
    cfg_valid = 1'b0;
    wait_state(ST_LOAD, "park_load");
    rxstrobe_in = 1'b1;
    #1 chk("load_blocked", 32'(rxstrobe_out), 32'd0);
    repeat (260) tick();
    rxstrobe_in = 1'b0;
    chk("drop_cnt_sat", 32'(drop_cnt), 32'd255);

    // Reset mid-load after words 0..4
    cfg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cfg_data = words[i];
      tick();
    end
    cfg_valid = 1'b0;
    chk("midload_cwrite", 32'(cwrite), 32'd1);
    chk("midload_cstate", 32'(cstate), 32'd4);
    #2 reset = 1'b0;
    #1;
    chk("arst_cwrite", 32'(cwrite), 32'd0);
    chk("arst_state", 32'(fsm_state), 32'(ST_IDLE));
    chk("arst_cfg_err", 32'(cfg_err), 32'd0);
    chk("arst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("arst_match_cnt", 32'(match_cnt), 32'd0);
    chk("arst_cdata", cdata, 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_state", 32'(fsm_state), 32'(ST_IDLE));
    chk("post_rst_cwrite", 32'(cwrite), 32'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
